// File: rtl/float_addsub_pipe_if.sv
// Operand/result handshake bundle for float_addsub_pipe.
// The master drives operands and out_ready; the slave (the pipe) drives results and in_ready.
interface float_addsub_pipe_if #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23,
  parameter int unsigned TAG_W  = 4
);
  localparam int unsigned W = 1 + EXP_W + MANT_W;

  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, op_sub, a, b, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag
  );

  modport slave (
    input  in_valid, op_sub, a, b, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag
  );
endinterface

// File: rtl/float_addsub_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise) with valid/ready
// back-pressure, round-toward-zero, flush-to-zero and infinity/NaN specials.
module float_addsub_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23,
  parameter int unsigned TAG_W  = 4
) (
  input logic                clk,
  input logic                rst,
  float_addsub_pipe_if.slave bus
);
  localparam int unsigned W    = 1 + EXP_W + MANT_W;
  localparam int unsigned MW   = MANT_W + 4;  // hidden + mant + 3 guard
  localparam int unsigned SW   = MANT_W + 5;  // plus carry
  localparam int unsigned LZ_W = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] NAN = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

  logic out_valid_q;
  logic [W-1:0] out_q;
  logic [TAG_W-1:0] out_tag_q;
  logic stall;

  assign stall         = out_valid_q && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_tag   = out_tag_q;

  // ---------------- S1: unpack, specials, swap, align ----------------
  logic sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MANT_W-1:0] ma, mb;
  logic a_zero, b_zero, a_inf, b_inf, a_ge;

  assign sa = bus.a[W-1];
  assign ea = bus.a[W-2:MANT_W];
  assign ma = bus.a[MANT_W-1:0];
  assign sb = bus.b[W-1] ^ bus.op_sub;
  assign eb = bus.b[W-2:MANT_W];
  assign mb = bus.b[MANT_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES);
  assign b_inf  = (eb == EXP_ONES);
  assign a_ge   = ({ea, ma} >= {eb, mb});

  logic spec_d;
  logic [W-1:0] spec_res_d;

  always_comb begin
    spec_d     = 1'b1;
    spec_res_d = '0;
    if (a_inf && b_inf) begin
      spec_res_d = (sa == sb) ? {sa, EXP_ONES, {MANT_W{1'b0}}} : NAN;
    end else if (a_inf) begin
      spec_res_d = {sa, EXP_ONES, {MANT_W{1'b0}}};
    end else if (b_inf) begin
      spec_res_d = {sb, EXP_ONES, {MANT_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      spec_res_d = '0;
    end else if (a_zero) begin
      spec_res_d = {sb, eb, mb};
    end else if (b_zero) begin
      spec_res_d = bus.a;
    end else begin
      spec_d = 1'b0;
    end
  end

  logic x_sign;
  logic [EXP_W-1:0] x_exp, y_exp, shift;
  logic [MANT_W-1:0] x_mant, y_mant;
  logic [MW-1:0] x_full, y_full, y_al;

  always_comb begin
    if (a_ge) begin
      x_sign = sa;
      x_exp  = ea;
      x_mant = ma;
      y_exp  = eb;
      y_mant = mb;
    end else begin
      x_sign = sb;
      x_exp  = eb;
      x_mant = mb;
      y_exp  = ea;
      y_mant = ma;
    end
    shift  = x_exp - y_exp;
    x_full = {1'b1, x_mant, 3'b000};
    y_full = {1'b1, y_mant, 3'b000};
    y_al   = (32'(shift) >= MW) ? '0 : (y_full >> shift);
  end

  logic s1_valid_q, s1_spec_q, s1_sign_q, s1_sub_q;
  logic [W-1:0] s1_spec_res_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MW-1:0] s1_mx_q, s1_my_q;
  logic [TAG_W-1:0] s1_tag_q;

  // ---------------- S2: mantissa add/sub ----------------
  logic [SW-1:0] sum_d;
  assign sum_d = s1_sub_q ? ({1'b0, s1_mx_q} - {1'b0, s1_my_q})
                          : ({1'b0, s1_mx_q} + {1'b0, s1_my_q});

  logic s2_valid_q, s2_spec_q, s2_sign_q;
  logic [W-1:0] s2_spec_res_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SW-1:0] s2_sum_q;
  logic [TAG_W-1:0] s2_tag_q;

  // ---------------- S3: normalise, range check, pack ----------------
  logic [LZ_W-1:0] lz;
  logic [MW-1:0] norm;
  logic signed [EXP_W+1:0] exp_ext, lz_ext, exp_r;
  logic [W-1:0] res_d;

  // Last assignment wins, so lz ends up set by the most significant one.
  always_comb begin
    lz = '0;
    for (int i = 0; i < int'(MW); i++) begin
      if (s2_sum_q[i]) lz = LZ_W'(int'(MW) - 1 - i);
    end
  end

  assign exp_ext = $signed({2'b00, s2_exp_q});
  assign lz_ext  = $signed({{(EXP_W + 2 - LZ_W){1'b0}}, lz});

  always_comb begin
    if (s2_sum_q[SW-1]) begin
      norm  = s2_sum_q[SW-1:1];
      exp_r = exp_ext + $signed({{(EXP_W + 1){1'b0}}, 1'b1});
    end else begin
      norm  = s2_sum_q[MW-1:0] << lz;
      exp_r = exp_ext - lz_ext;
    end

    if (s2_spec_q) begin
      res_d = s2_spec_res_q;
    end else if (s2_sum_q == '0) begin
      res_d = '0;
    end else if (exp_r[EXP_W+1] || (exp_r == '0)) begin
      res_d = {s2_sign_q, {(W-1){1'b0}}};
    end else if (exp_r >= $signed({2'b00, EXP_ONES})) begin
      res_d = {s2_sign_q, EXP_ONES, {MANT_W{1'b0}}};
    end else begin
      res_d = {s2_sign_q, exp_r[EXP_W-1:0], norm[MW-2:3]};
    end
  end

  // Hidden bit and guard bits are dropped by truncation.
  logic unused_norm;
  assign unused_norm = ^{norm[MW-1], norm[2:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q    <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_spec_res_q <= '0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_exp_q      <= '0;
      s1_mx_q       <= '0;
      s1_my_q       <= '0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_spec_res_q <= '0;
      s2_sign_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      s2_tag_q      <= '0;
      out_valid_q   <= 1'b0;
      out_q         <= '0;
      out_tag_q     <= '0;
    end else if (!stall) begin
      s1_valid_q    <= bus.in_valid;
      s1_spec_q     <= spec_d;
      s1_spec_res_q <= spec_res_d;
      s1_sign_q     <= x_sign;
      s1_sub_q      <= sa ^ sb;
      s1_exp_q      <= x_exp;
      s1_mx_q       <= x_full;
      s1_my_q       <= y_al;
      s1_tag_q      <= bus.in_tag;
      s2_valid_q    <= s1_valid_q;
      s2_spec_q     <= s1_spec_q;
      s2_spec_res_q <= s1_spec_res_q;
      s2_sign_q     <= s1_sign_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= sum_d;
      s2_tag_q      <= s1_tag_q;
      out_valid_q   <= s2_valid_q;
      out_q         <= res_d;
      out_tag_q     <= s2_tag_q;
    end
  end
endmodule

// File: tb/tb_float_addsub_pipe.sv
// Self-checking bench for float_addsub_pipe: vector table through a scoreboard plus
// latency, back-to-back, stall and mid-flight reset sequences.
module tb_float_addsub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  float_addsub_pipe_if #(.EXP_W(8), .MANT_W(23), .TAG_W(4)) bus ();

  float_addsub_pipe #(.EXP_W(8), .MANT_W(23), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  exp_t sb_q[$];
  int   pop_cyc[$];
  vec_t vecs[19];
  int   errors = 0;
  int   checks = 0;
  int   pops = 0;
  int   cyc = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_out;
  logic [3:0]  prev_tag;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Output monitor: transfers are decided at the negedge because out_ready only moves
  // just after a posedge.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", bus.out_valid, 1);
        chk("stall_hold_out", {bus.out_tag, bus.out}, {prev_tag, prev_out});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", {bus.out_tag, bus.out}, 64'hDEAD_0000_0000_0000);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_result", bus.out, e.res);
          chk("sb_tag", bus.out_tag, e.tag);
        end
        pops++;
        pop_cyc.push_back(cyc);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = bus.out;
      prev_tag   = bus.out_tag;
    end
  end

  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] res);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_sub   = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_tag   = tag;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb_q.push_back('{res: res, tag: tag});
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Single op: accepted on edge N, visible after edge N+2.
  task automatic lat_test(input string name, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag, input logic [31:0] res);
    send(op, a, b, tag, res);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({name, "_n0"}, bus.out_valid, 0);
    @(negedge clk);
    chk({name, "_n1"}, bus.out_valid, 0);
    @(negedge clk);
    chk({name, "_n2"}, bus.out_valid, 1);
    chk({name, "_out"}, bus.out, res);
    chk({name, "_tag"}, bus.out_tag, tag);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000};
    vecs[1]  = '{1'b1, 32'h40400000, 32'h3F800000, 32'h40000000};
    vecs[2]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000};
    vecs[3]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    vecs[4]  = '{1'b1, 32'h00800001, 32'h00800000, 32'h00000000};
    vecs[5]  = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000};
    vecs[6]  = '{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000};
    vecs[7]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000};
    vecs[8]  = '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000};
    vecs[9]  = '{1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000};
    vecs[10] = '{1'b0, 32'h3F800000, 32'h00000000, 32'h3F800000};
    vecs[11] = '{1'b1, 32'h00000000, 32'h3F800000, 32'hBF800000};
    vecs[12] = '{1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000};
    vecs[13] = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000};
    vecs[14] = '{1'b0, 32'h4B800000, 32'h3F800000, 32'h4B800000};
    vecs[15] = '{1'b0, 32'h4F800000, 32'h3F800000, 32'h4F800000};
    vecs[16] = '{1'b1, 32'h3FC00000, 32'h3F800000, 32'h3F000000};
    vecs[17] = '{1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[18] = '{1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000};

    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out", bus.out, 0);
    chk("reset_out_tag", bus.out_tag, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_in_ready", bus.in_ready, 1);

    lat_test("latency", 1'b0, 32'h3F800000, 32'h40000000, 4'h5, 32'h40400000);

    foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].res);
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back: results must emerge on consecutive cycles.
    pop_cyc.delete();
    for (int i = 0; i < 4; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].res);
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain();
    chk("b2b_count", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("b2b_consecutive", pop_cyc[i] - pop_cyc[0], i);
    end

    // Stall for 2 cycles mid-stream.
    p0 = pops;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].res);
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        #1;
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_no_loss", pops - p0, 4);

    // Reset with the first result at the output and two more in flight.
    for (int i = 8; i < 11; i++) send(1'b0, 32'h3F800000, 32'h3F800000, 4'(i), 32'h40000000);
    bus.in_valid = 1'b0;
    #2;
    chk("rst_pre_valid", bus.out_valid, 1);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    lat_test("post_reset", 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'h3, 32'h7F800000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
